free_list: RTL and testbench

- Circular FIFO of unallocated physical register indices; the responder side of the decode→free-list allocation interface.
- Decode pops one PRD per renamed instruction that writes rd≠x0.
- ROB commit pushes back the previous mapping of a committed rd.
- A second (retire) head pointer lets a flush instantly return all speculative allocations.

---
 rtl/free_list_pkg.sv | 26 ++
 rtl/free_list_checker.sv | 28 ++
 rtl/free_list.sv | 86 ++++++++
 tb/tb_free_list.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/free_list_pkg.sv
// Shared rename parameters and types: physical register file sizing and
// free-list pointer geometry used by the free list, rename and ROB.
package free_list_pkg;

    localparam int PRF_SIZE      = 64;
    localparam int ARCH_REGS     = 32;
    localparam int PRF_IDX_HIBIT = $clog2(PRF_SIZE) - 1;
    localparam int FREE_DEPTH    = PRF_SIZE - ARCH_REGS;
    localparam int FREE_PTR_W    = $clog2(FREE_DEPTH) + 1;
    localparam int FREE_IDX_W    = FREE_PTR_W - 1;

    typedef logic [PRF_IDX_HIBIT:0] prd_t;
    typedef logic [FREE_PTR_W-1:0]  free_ptr_t;

    // Advance a wrap-bit pointer by one when enabled; index bits wrap naturally.
    function automatic free_ptr_t ptr_advance(input free_ptr_t ptr, input logic en);
        free_ptr_t result;
        if (en) begin
            result = ptr + free_ptr_t'(1'b1);
        end else begin
            result = ptr;
        end
        return result;
    endfunction

endpackage

// File: rtl/free_list_checker.sv
// Protocol checks for the free list: illegal pops, overflowing commits and
// attempts to free p0. Reports only; the datapath handles each case itself.
module free_list_checker
    import free_list_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    input logic                   id_free_dequeue,
    input logic                   flush,
    input logic                   free_empty,
    input logic                   rob_commit,
    input logic                   commit_full,
    input logic [PRF_IDX_HIBIT:0] rob_free_prd
);

    pop_when_empty_a: assert property (@(posedge clk) disable iff (rst)
        !(id_free_dequeue && free_empty && !flush))
        else $warning("free_list: dequeue while empty ignored");

    commit_when_full_a: assert property (@(posedge clk) disable iff (rst)
        !(rob_commit && commit_full))
        else $warning("free_list: commit while full dropped");

    free_p0_a: assert property (@(posedge clk) disable iff (rst)
        !(rob_commit && (rob_free_prd == '0)))
        else $warning("free_list: commit freed p0");

endmodule

// File: rtl/free_list.sv
// Circular free list of physical register indices with a speculative pop head,
// a retire head for instant flush recovery, and a commit-driven tail.
module free_list
    import free_list_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_free_dequeue,
    output logic [PRF_IDX_HIBIT:0] free_id_prd,
    output logic                   free_empty,
    output logic [FREE_PTR_W-1:0]  free_count,
    input  logic                   rob_commit,
    input  logic [PRF_IDX_HIBIT:0] rob_free_prd,
    input  logic                   flush
);

    prd_t      entry_r [FREE_DEPTH];
    free_ptr_t spec_head_r;
    free_ptr_t retire_head_r;
    free_ptr_t tail_r;

    free_ptr_t count_s;
    logic      full_s;
    logic      pop_ok_s;
    logic      commit_ok_s;
    free_ptr_t spec_head_next_s;
    free_ptr_t retire_head_next_s;
    free_ptr_t tail_next_s;

    // Occupancy and legality of this cycle's pop and push.
    // Full means every entry is free, so no speculative PRD exists to retire.
    always_comb begin
        count_s     = tail_r - spec_head_r;
        full_s      = (tail_r[FREE_IDX_W-1:0] == spec_head_r[FREE_IDX_W-1:0]) &&
                      (tail_r[FREE_IDX_W] != spec_head_r[FREE_IDX_W]);
        pop_ok_s    = id_free_dequeue && (count_s != free_ptr_t'(0)) && !flush;
        commit_ok_s = rob_commit && !full_s;
    end

    // Pointer updates; flush takes the retire head after this cycle's commit.
    always_comb begin
        retire_head_next_s = ptr_advance(retire_head_r, commit_ok_s);
        tail_next_s        = ptr_advance(tail_r, commit_ok_s);
        spec_head_next_s   = spec_head_r;
        if (flush) begin
            spec_head_next_s = retire_head_next_s;
        end else begin
            spec_head_next_s = ptr_advance(spec_head_r, pop_ok_s);
        end
    end

    // Pointer and storage state; reset loads the initial pool p32..p63.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FREE_DEPTH; i++) begin
                entry_r[i] <= prd_t'(ARCH_REGS + i);
            end
            spec_head_r   <= '0;
            retire_head_r <= '0;
            tail_r        <= free_ptr_t'(FREE_DEPTH);
        end else begin
            spec_head_r   <= spec_head_next_s;
            retire_head_r <= retire_head_next_s;
            tail_r        <= tail_next_s;
            if (commit_ok_s) begin
                entry_r[tail_r[FREE_IDX_W-1:0]] <= rob_free_prd;
            end
        end
    end

    assign free_id_prd = entry_r[spec_head_r[FREE_IDX_W-1:0]];
    assign free_count  = count_s;
    assign free_empty  = (count_s == free_ptr_t'(0));

    free_list_checker u_checker (
        .clk             (clk),
        .rst             (rst),
        .id_free_dequeue (id_free_dequeue),
        .flush           (flush),
        .free_empty      (free_empty),
        .rob_commit      (rob_commit),
        .commit_full     (full_s),
        .rob_free_prd    (rob_free_prd)
    );

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset, drain, commit wrap, flush recovery and
// same-cycle corner cases with hand-computed expectations.
module tb_free_list;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_free_dequeue;
    logic [5:0] free_id_prd;
    logic       free_empty;
    logic [5:0] free_count;
    logic       rob_commit;
    logic [5:0] rob_free_prd;
    logic       flush;

    int tests_run = 0;
    int failures  = 0;

    free_list dut (
        .clk             (clk),
        .rst             (rst),
        .id_free_dequeue (id_free_dequeue),
        .free_id_prd     (free_id_prd),
        .free_empty      (free_empty),
        .free_count      (free_count),
        .rob_commit      (rob_commit),
        .rob_free_prd    (rob_free_prd),
        .flush           (flush)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        id_free_dequeue = 1'b0;
        rob_commit = 1'b0;
        rob_free_prd = 6'd0;
        flush = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic pop_n(input int n);
        id_free_dequeue = 1'b1;
        repeat (n) step();
        id_free_dequeue = 1'b0;
    endtask

    task automatic commit_one(input logic [5:0] prd);
        rob_commit = 1'b1;
        rob_free_prd = prd;
        step();
        rob_commit = 1'b0;
        rob_free_prd = 6'd0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (free_id_prd !== 6'd32) begin failures++; $display("FAIL reset_prd: got %0d expected 32", free_id_prd); end
        tests_run++;
        if (free_count !== 6'd32) begin failures++; $display("FAIL reset_count: got %0d expected 32", free_count); end
        tests_run++;
        if (free_empty !== 1'b0) begin failures++; $display("FAIL reset_empty: got %0b expected 0", free_empty); end
        pop_n(5);
        tests_run++;
        if (free_id_prd !== 6'd37 || free_count !== 6'd27) begin
            failures++; $display("FAIL five_pops: prd %0d count %0d expected 37 27", free_id_prd, free_count);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (free_id_prd !== 6'd32 || free_count !== 6'd32 || free_empty !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: prd %0d count %0d empty %0b expected 32 32 0", free_id_prd, free_count, free_empty);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_drain();
        logic [5:0] exp_prd;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            exp_prd = 6'(32 + i);
            tests_run++;
            if (free_id_prd !== exp_prd) begin failures++; $display("FAIL drain_prd[%0d]: got %0d expected %0d", i, free_id_prd, exp_prd); end
            pop_n(1);
        end
        tests_run++;
        if (free_empty !== 1'b1 || free_count !== 6'd0) begin
            failures++; $display("FAIL drain_empty: empty %0b count %0d expected 1 0", free_empty, free_count);
        end
        pop_n(1);
        tests_run++;
        if (free_empty !== 1'b1 || free_count !== 6'd0 || free_id_prd !== 6'd32) begin
            failures++;
            $display("FAIL pop_when_empty: empty %0b count %0d prd %0d expected 1 0 32", free_empty, free_count, free_id_prd);
        end
    endtask

    task automatic test_commit_wrap();
        logic [5:0] exp_prd;
        do_reset();
        pop_n(32);
        commit_one(6'd5);
        commit_one(6'd7);
        commit_one(6'd9);
        tests_run++;
        if (free_count !== 6'd3 || free_empty !== 1'b0) begin
            failures++; $display("FAIL commit_count: count %0d empty %0b expected 3 0", free_count, free_empty);
        end
        for (int i = 0; i < 3; i++) begin
            exp_prd = 6'(5 + 2 * i);
            tests_run++;
            if (free_id_prd !== exp_prd) begin failures++; $display("FAIL commit_pop[%0d]: got %0d expected %0d", i, free_id_prd, exp_prd); end
            pop_n(1);
        end
        tests_run++;
        if (free_empty !== 1'b1) begin failures++; $display("FAIL commit_drained: empty %0b expected 1", free_empty); end
        // Tail index is 3 here, so the next push lands where spec head now points.
        commit_one(6'd11);
        tests_run++;
        if (free_id_prd !== 6'd11 || free_count !== 6'd1) begin
            failures++; $display("FAIL tail_wrap: prd %0d count %0d expected 11 1", free_id_prd, free_count);
        end
    endtask

    task automatic test_flush();
        logic [5:0] exp_prd;
        do_reset();
        pop_n(4);
        commit_one(6'd10);
        tests_run++;
        if (free_count !== 6'd29) begin failures++; $display("FAIL preflush_count: got %0d expected 29", free_count); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests_run++;
        if (free_count !== 6'd32 || free_id_prd !== 6'd33) begin
            failures++; $display("FAIL flush_restore: count %0d prd %0d expected 32 33", free_count, free_id_prd);
        end
        for (int i = 0; i < 32; i++) begin
            exp_prd = (i == 31) ? 6'd10 : 6'(33 + i);
            tests_run++;
            if (free_id_prd !== exp_prd) begin failures++; $display("FAIL flush_pop[%0d]: got %0d expected %0d", i, free_id_prd, exp_prd); end
            pop_n(1);
        end
        tests_run++;
        if (free_empty !== 1'b1) begin failures++; $display("FAIL flush_drained: empty %0b expected 1", free_empty); end
    endtask

    task automatic test_flush_same_cycle();
        do_reset();
        pop_n(2);
        flush = 1'b1;
        id_free_dequeue = 1'b1;
        rob_commit = 1'b1;
        rob_free_prd = 6'd40;
        step();
        flush = 1'b0;
        id_free_dequeue = 1'b0;
        rob_commit = 1'b0;
        rob_free_prd = 6'd0;
        tests_run++;
        if (free_count !== 6'd32 || free_id_prd !== 6'd33) begin
            failures++; $display("FAIL flush_combo: count %0d prd %0d expected 32 33", free_count, free_id_prd);
        end
        pop_n(1);
        tests_run++;
        if (free_id_prd !== 6'd34 || free_count !== 6'd31) begin
            failures++; $display("FAIL flush_combo_next: prd %0d count %0d expected 34 31", free_id_prd, free_count);
        end
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        pop_n(32);
        id_free_dequeue = 1'b1;
        rob_commit = 1'b1;
        rob_free_prd = 6'd12;
        step();
        id_free_dequeue = 1'b0;
        rob_commit = 1'b0;
        rob_free_prd = 6'd0;
        tests_run++;
        if (free_id_prd !== 6'd12 || free_empty !== 1'b0 || free_count !== 6'd1) begin
            failures++;
            $display("FAIL empty_bypass: prd %0d empty %0b count %0d expected 12 0 1", free_id_prd, free_empty, free_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pop_n(3);
        id_free_dequeue = 1'b1;
        rob_commit = 1'b1;
        rob_free_prd = 6'd20;
        step();
        id_free_dequeue = 1'b0;
        rob_commit = 1'b0;
        tests_run++;
        if (free_id_prd !== 6'd36 || free_count !== 6'd29) begin
            failures++; $display("FAIL push_pop: prd %0d count %0d expected 36 29", free_id_prd, free_count);
        end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_commit_wrap();
        test_flush();
        test_flush_same_cycle();
        test_empty_push_pop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
